// File: rtl/tile_grid_renderer.sv
// tile_grid_renderer: GRID_W x GRID_H tile store with a valid/ready write
// port, a clear sequencer and a 2-stage pixel colour pipeline for vga_sync.
// Optional build macro: TILE_CORNER_CUT_EN removes the pixels whose
// Manhattan distance to a tile corner is below RADIUS.
//
// Write handshake: a write is accepted on any cycle where wr_valid && wr_ready
// at the rising edge of iCLK. wr_ready is high only in IDLE with clr low, so a
// writer whose request meets a clr must hold wr_valid until wr_ready returns.
module tile_grid_renderer #(
    parameter int GRID_W   = 4,
    parameter int GRID_H   = 4,
    parameter int TILE_DIM = 100,
    parameter int MARGIN   = 10,
    parameter int X_OFF    = 100,
    parameter int Y_OFF    = 20,
    parameter int VAL_W    = 4,
    parameter int COORD_W  = 10,
    parameter int RADIUS   = 3
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_x,
    input  logic [2:0]         wr_y,
    input  logic [VAL_W-1:0]   wr_val,
    input  logic               clr,
    output logic               o_busy,
    output logic               o_wr_err,
    output logic [9:0]         oRed,
    output logic [9:0]         oGreen,
    output logic [9:0]         oBlue,
    output logic               o_tile_hit,
    output logic [VAL_W-1:0]   o_tile_val,
    output logic               dbg_state
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;
    // Two extra bits so tile origins past 2^COORD_W never wrap into the screen.
    localparam int CW2   = COORD_W + 2;

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [VAL_W-1:0]   cells [NCELL];

    logic               wr_acc;
    logic               wr_oor;
    logic [IDX_W-1:0]   wr_idx;

    logic [CW2-1:0]     px_e, py_e;
    logic               col_any, row_any, in_tile;
    logic [2:0]         col_sel, row_sel;
    logic [2:0]         s1_col, s1_row;
    logic               s1_in;
    logic [IDX_W-1:0]   rd_idx;
    logic [VAL_W-1:0]   rd_val;

`ifdef TILE_CORNER_CUT_EN
    logic [CW2-1:0]     ox_sel, oy_sel;
    logic [CW2-1:0]     lx, ly, rx, ry, mx, my;
    logic [CW2:0]       dist_v;
    logic               cut;
`else
    localparam int unused_radius = RADIUS;
`endif

    // Colour lookup for a stored tile value.
    function automatic logic [29:0] palette(input logic [VAL_W-1:0] v);
        case (int'(v))
            0:       return {10'h000, 10'h000, 10'h000};
            1:       return {10'h000, 10'h3FF, 10'h3FF};
            2:       return {10'h3FF, 10'h000, 10'h3FF};
            3:       return {10'h3FF, 10'h3FF, 10'h000};
            4:       return {10'h000, 10'h000, 10'h3FF};
            5:       return {10'h3FF, 10'h000, 10'h000};
            6:       return {10'h000, 10'h3FF, 10'h000};
            default: return {10'h3FF, 10'h3FF, 10'h3FF};
        endcase
    endfunction

    assign wr_acc    = wr_valid && wr_ready;
    assign wr_oor    = (int'(wr_x) >= GRID_W) || (int'(wr_y) >= GRID_H);
    assign wr_idx    = IDX_W'(int'(wr_y) * GRID_W + int'(wr_x));
    assign dbg_state = (state == S_CLEAR);

    // Sequencer state and clear index register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next state: clr always (re)starts the clear from cell 0.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            S_IDLE: begin
                if (clr) begin
                    state_n = S_CLEAR;
                    idx_n   = '0;
                end
            end
            S_CLEAR: begin
                if (clr) begin
                    idx_n = '0;
                end else if (idx == IDX_W'(NCELL - 1)) begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Sequencer outputs; wr_ready is held low while reset is asserted.
    always_comb begin
        wr_ready = 1'b0;
        o_busy   = 1'b0;
        case (state)
            S_IDLE:  wr_ready = iRST_N && !clr;
            S_CLEAR: o_busy   = 1'b1;
            default: ;
        endcase
    end

    // Tile store: clear sequencer and write port never overlap (no ready in CLEAR).
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NCELL; i++) cells[i] <= '0;
        end else if (state == S_CLEAR) begin
            cells[idx] <= '0;
        end else if (wr_acc && !wr_oor) begin
            cells[wr_idx] <= wr_val;
        end
    end

    // Error pulse the cycle after an out-of-range write is accepted.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) o_wr_err <= 1'b0;
        else         o_wr_err <= wr_acc && wr_oor;
    end

    // Stage-1 decode: one comparator pair per column and per row.
    always_comb begin
        logic [CW2-1:0] o;
        o       = '0;
        px_e    = CW2'(px);
        py_e    = CW2'(py);
        col_any = 1'b0;
        row_any = 1'b0;
        col_sel = '0;
        row_sel = '0;
`ifdef TILE_CORNER_CUT_EN
        ox_sel  = '0;
        oy_sel  = '0;
`endif
        for (int c = 0; c < GRID_W; c++) begin
            o = CW2'(X_OFF + MARGIN + (TILE_DIM + MARGIN) * c);
            if (px_e >= o && px_e < o + CW2'(TILE_DIM)) begin
                col_any = 1'b1;
                col_sel = 3'(c);
`ifdef TILE_CORNER_CUT_EN
                ox_sel  = o;
`endif
            end
        end
        for (int r = 0; r < GRID_H; r++) begin
            o = CW2'(Y_OFF + MARGIN + (TILE_DIM + MARGIN) * r);
            if (py_e >= o && py_e < o + CW2'(TILE_DIM)) begin
                row_any = 1'b1;
                row_sel = 3'(r);
`ifdef TILE_CORNER_CUT_EN
                oy_sel  = o;
`endif
            end
        end
    end

`ifdef TILE_CORNER_CUT_EN
    // Distance to the nearest corner is the nearer x edge plus the nearer y edge.
    always_comb begin
        lx     = px_e - ox_sel;
        ly     = py_e - oy_sel;
        rx     = CW2'(TILE_DIM - 1) - lx;
        ry     = CW2'(TILE_DIM - 1) - ly;
        mx     = (lx < rx) ? lx : rx;
        my     = (ly < ry) ? ly : ry;
        dist_v = {1'b0, mx} + {1'b0, my};
        cut    = dist_v < (CW2 + 1)'(RADIUS);
    end
    assign in_tile = col_any && row_any && !cut;
`else
    assign in_tile = col_any && row_any;
`endif

    // Stage-1 pipeline register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_col <= '0;
            s1_row <= '0;
            s1_in  <= 1'b0;
        end else begin
            s1_col <= col_sel;
            s1_row <= row_sel;
            s1_in  <= in_tile;
        end
    end

    assign rd_idx = IDX_W'(int'(s1_row) * GRID_W + int'(s1_col));
    assign rd_val = cells[rd_idx];

    // Stage-2: cell read and registered colour / hit outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
            o_tile_hit <= 1'b0;
            o_tile_val <= '0;
        end else if (s1_in) begin
            {oRed, oGreen, oBlue} <= palette(rd_val);
            o_tile_hit <= 1'b1;
            o_tile_val <= rd_val;
        end else begin
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
            o_tile_hit <= 1'b0;
            o_tile_val <= '0;
        end
    end

endmodule

// File: tb/tb_tile_grid_renderer.sv
// Bench for tile_grid_renderer with default geometry: tiles at
// x = 110,220,330,440 and y = 30,140,250,360, each 100 pixels wide.
module tb_tile_grid_renderer;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic [9:0] px = '0, py = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_x = '0, wr_y = '0;
    logic [3:0] wr_val = '0;
    logic       clr = 1'b0;
    logic       o_busy, o_wr_err;
    logic [9:0] oRed, oGreen, oBlue;
    logic       o_tile_hit;
    logic [3:0] o_tile_val;
    logic       dbg_state;

    int total = 0;
    int bad   = 0;

    logic [34:0] exp_q[$];
    logic        pv = 1'b0, tv1 = 1'b0, tv2 = 1'b0;

    localparam logic [9:0] Z = 10'h000;
    localparam logic [9:0] F = 10'h3FF;

    tile_grid_renderer #(
        .GRID_W(4), .GRID_H(4), .TILE_DIM(100), .MARGIN(10),
        .X_OFF(100), .Y_OFF(20), .VAL_W(4), .COORD_W(10), .RADIUS(3)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .px(px), .py(py),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_val(wr_val), .clr(clr), .o_busy(o_busy), .o_wr_err(o_wr_err),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .o_tile_hit(o_tile_hit), .o_tile_val(o_tile_val), .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 iCLK = ~iCLK;
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    // Two-cycle marker delay line matching the pixel pipeline.
    always @(posedge iCLK) begin
        tv1 <= pv;
        tv2 <= tv1;
    end

    // Monitor: compare each presented pixel against the expected queue.
    always @(negedge iCLK) begin
        logic [34:0] act, e;
        if (tv2) begin
            act = {o_tile_hit, o_tile_val, oRed, oGreen, oBlue};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pixel: got %h with no expected entry", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL pixel px=%0d py=%0d: got %h want %h", px, py, act, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] ex(input logic h, input logic [3:0] v,
                                       input logic [9:0] r, input logic [9:0] g,
                                       input logic [9:0] b);
        return {h, v, r, g, b};
    endfunction

    function automatic int cx(input int c); return 160 + 110 * c; endfunction
    function automatic int cy(input int r); return 80 + 110 * r; endfunction

    task automatic pix(input int x, input int y, input logic [34:0] e);
        px = 10'(x);
        py = 10'(y);
        pv = 1'b1;
        exp_q.push_back(e);
        @(negedge iCLK);
    endtask

    task automatic drain();
        pv = 1'b0;
        repeat (3) @(negedge iCLK);
    endtask

    task automatic do_write(input int x, input int y, input int v, input logic exp_err);
        wr_x = 3'(x);
        wr_y = 3'(y);
        wr_val = 4'(v);
        wr_valid = 1'b1;
        #1 check("wr_ready", wr_ready, 1);
        @(negedge iCLK);
        wr_valid = 1'b0;
        #1 check("wr_err_pulse", o_wr_err, exp_err);
        @(negedge iCLK);
        check("wr_err_after", o_wr_err, 0);
    endtask

    task automatic run_clear(input logic restart, input int exp_len);
        int n;
        n = 0;
        clr = 1'b1;
        #1 check("ready_on_clr", wr_ready, 0);
        @(negedge iCLK);
        clr = 1'b0;
        while (o_busy && n < 100) begin
            n++;
            check("ready_in_clear", wr_ready, 0);
            clr = (restart && n == 8);
            @(negedge iCLK);
        end
        clr = 1'b0;
        check("busy_len", n, exp_len);
    endtask

    initial begin
        int n;
        // Reset state.
        repeat (3) @(negedge iCLK);
        check("rst_rgb", {oRed, oGreen, oBlue}, 0);
        check("rst_hit", o_tile_hit, 0);
        check("rst_val", o_tile_val, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_wr_err, 0);
        check("rst_ready", wr_ready, 0);
        iRST_N = 1'b1;
        #1 check("ready_after_rst", wr_ready, 1);
        @(negedge iCLK);

        // Empty-grid sweep along a row that crosses the tile row 0.
        for (int x = 0; x < 640; x++) begin
            logic h;
            h = (x >= 110 && x <= 209) || (x >= 220 && x <= 319) ||
                (x >= 330 && x <= 429) || (x >= 440 && x <= 539);
            pix(x, 100, ex(h, 0, Z, Z, Z));
        end
        drain();

        // Single write and tile boundaries.
        do_write(1, 2, 3, 0);
        pix(230, 270, ex(1, 3, F, F, Z));
        pix(319, 270, ex(1, 3, F, F, Z));
        pix(320, 270, ex(0, 0, Z, Z, Z));
        pix(329, 270, ex(0, 0, Z, Z, Z));
        pix(330, 270, ex(1, 0, Z, Z, Z));
        pix(230, 249, ex(0, 0, Z, Z, Z));
        pix(230, 250, ex(1, 3, F, F, Z));
        pix(230, 349, ex(1, 3, F, F, Z));
        pix(230, 350, ex(0, 0, Z, Z, Z));
        pix(640, 80,  ex(0, 0, Z, Z, Z));
        drain();

        // Out-of-range writes leave every cell alone.
        do_write(4, 0, 5, 1);
        do_write(0, 4, 5, 1);
        pix(cx(0), cy(0), ex(1, 0, Z, Z, Z));
        pix(cx(0), cy(1), ex(1, 0, Z, Z, Z));
        pix(230, 270, ex(1, 3, F, F, Z));
        drain();

        // Palette coverage.
        do_write(0, 3, 1, 0);
        do_write(1, 3, 2, 0);
        do_write(2, 3, 4, 0);
        do_write(3, 3, 5, 0);
        do_write(0, 1, 7, 0);
        do_write(1, 1, 15, 0);
        pix(cx(0), cy(3), ex(1, 1,  Z, F, F));
        pix(cx(1), cy(3), ex(1, 2,  F, Z, F));
        pix(cx(2), cy(3), ex(1, 4,  Z, Z, F));
        pix(cx(3), cy(3), ex(1, 5,  F, Z, Z));
        pix(cx(0), cy(1), ex(1, 7,  F, F, F));
        pix(cx(1), cy(1), ex(1, 15, F, F, F));
        drain();

        // Fill, clear, and check every centre.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) do_write(c, r, 6, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pix(cx(c), cy(r), ex(1, 6, Z, F, Z));
        drain();
        run_clear(0, 16);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pix(cx(c), cy(r), ex(1, 0, Z, Z, Z));
        drain();

        // Clear restarted at its eighth cycle.
        run_clear(1, 24);

        // clr beats a same-cycle write; the held write lands after the clear.
        wr_x = 3'd2; wr_y = 3'd1; wr_val = 4'd4; wr_valid = 1'b1;
        clr = 1'b1;
        #1 check("ready_clr_collide", wr_ready, 0);
        @(negedge iCLK);
        clr = 1'b0;
        n = 0;
        while (o_busy && n < 100) begin
            n++;
            check("ready_hold", wr_ready, 0);
            @(negedge iCLK);
        end
        check("collide_busy_len", n, 16);
        #1 check("ready_after_clear", wr_ready, 1);
        @(negedge iCLK);
        wr_valid = 1'b0;
        pix(cx(2), cy(1), ex(1, 4, Z, Z, F));
        drain();

        // Corner pixels.
        do_write(0, 0, 2, 0);
`ifdef TILE_CORNER_CUT_EN
        pix(110, 30,  ex(0, 0, Z, Z, Z));
        pix(112, 30,  ex(0, 0, Z, Z, Z));
        pix(113, 30,  ex(1, 2, F, Z, F));
        pix(209, 129, ex(0, 0, Z, Z, Z));
        pix(111, 31,  ex(0, 0, Z, Z, Z));
        pix(112, 31,  ex(1, 2, F, Z, F));
`else
        pix(110, 30,  ex(1, 2, F, Z, F));
        pix(113, 30,  ex(1, 2, F, Z, F));
        pix(209, 129, ex(1, 2, F, Z, F));
`endif
        drain();

        // Asynchronous reset in the middle of a clear.
        do_write(3, 3, 7, 0);
        pix(cx(3), cy(3), ex(1, 7, F, F, F));
        drain();
        clr = 1'b1;
        @(negedge iCLK);
        clr = 1'b0;
        repeat (2) @(negedge iCLK);
        check("busy_mid_clear", o_busy, 1);
        check("dbg_mid_clear", dbg_state, 1);
        check("rgb_before_rst", {oRed, oGreen, oBlue}, {F, F, F});
        #2 iRST_N = 1'b0;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_dbg", dbg_state, 0);
        check("arst_rgb", {oRed, oGreen, oBlue}, 0);
        check("arst_hit", o_tile_hit, 0);
        check("arst_val", o_tile_val, 0);
        check("arst_ready", wr_ready, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        #1 check("ready_after_arst", wr_ready, 1);
        @(negedge iCLK);
        pix(cx(3), cy(3), ex(1, 0, Z, Z, Z));
        pix(cx(0), cy(0), ex(1, 0, Z, Z, Z));
        drain();

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
